product_accumulator: RTL
========================

Name: product_accumulator

Overview:
- Downstream consumer of the 2x2 multiplier. Takes its 4-bit product stream through a valid/ready handshake and accumulates COUNT consecutive products into one sum.
- Presents that sum as a single result with its own valid/ready handshake.
- Forms the accumulate stage of a small dot-product / MAC datapath built around the 2x2 multiplier.

Parameters:
- ACC_W, 8, accumulator and result width in bits (must be >= 4).
- COUNT, 4, number of products summed per result (must be >= 1).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- clear  input  1  synchronous abort of the current frame.
- in_valid  input  1  product on p is valid.
- in_ready  output  1  block can accept a product this cycle.
- p  input  4  unsigned product from the 2x2 multiplier, range 0..9.
- out_valid  output  1  acc_out holds a completed result.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  accumulated sum of COUNT products.
- overflow  output  1  the frame's sum exceeded ACC_W bits; valid while out_valid=1.

Behaviour:
- Interface: one clock. Reset is synchronous and active-low (rst_n sampled on rising clk). No asynchronous paths.
- Reset values (rst_n=0 at edge):
  - state=ACCUM, acc=0, cnt=0.
  - acc_out=0, out_valid=0, overflow=0, in_ready=1 (combinational from state).
- Priority per edge: rst_n low > clear high > normal operation.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Transfer occurs when in_valid=1 (in_ready is 1). On transfer: sum = acc + zero-extended p, computed at ACC_W+1 bits.
  - If bit ACC_W of sum is 1, set the sticky frame-overflow flag.
  - If cnt != COUNT-1: acc <= sum[ACC_W-1:0], cnt <= cnt+1.
  - If cnt == COUNT-1: acc_out <= final sum (see overflow rule), overflow <= sticky flag OR this carry, out_valid <= 1, state <= HOLD.
  - in_valid=0: no change.
- State HOLD:
  - in_ready=0, out_valid=1. acc_out and overflow stay stable until accepted.
  - out_ready=1: state <= ACCUM, acc <= 0, cnt <= 0, sticky flag <= 0, out_valid <= 0.
  - acc_out keeps its last value after the handshake. overflow is cleared.
  - No product is accepted in the handshake cycle (in_ready is 0 in HOLD).
- Latency: out_valid rises on the edge that accepts the COUNTth product, i.e. it is visible the cycle after that transfer. Throughput is one product per cycle in ACCUM, plus at least one HOLD cycle per result.
- COUNT=1: every accepted product goes directly to HOLD.
- Counter width: clog2(COUNT), minimum 1 bit. cnt never exceeds COUNT-1.
- Overflow, default build: wrap-around. acc and acc_out keep the low ACC_W bits, overflow=1 if any carry occurred during the frame.
- clear=1, any state: state <= ACCUM, acc <= 0, cnt <= 0, sticky flag <= 0, out_valid <= 0, overflow <= 0. An in_valid in the same cycle is discarded; the product is not accumulated. acc_out is unchanged.
- Reset mid-frame: partial sum is discarded and all outputs return to reset values on that edge.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: on any carry out of bit ACC_W-1, acc clamps to all ones and stays there for the rest of the frame. Further additions do not wrap. acc_out = 2^ACC_W-1; overflow still reports 1.
- Undefined: wrap-around as described in Behaviour.

Test Plan:
- Defaults (ACC_W=8, COUNT=4): rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, acc_out=0, overflow=0.
- Defaults: p=9,9,9,9 on back-to-back in_valid, out_ready=1 -> out_valid high exactly 1 cycle after 4th transfer, acc_out=36 (0x24), overflow=0, then back in ACCUM.
- Defaults: p=1,2,3,4 with in_valid gaps, out_ready held 0 for 3 cycles -> acc_out=10 stable and in_ready=0 throughout HOLD; release -> next frame starts from 0 (p=5 x4 gives 20).
- ACC_W=5, COUNT=4: p=9 x4 -> without macro acc_out=4, overflow=1; with PRODUCT_ACCUMULATOR_SATURATE_EN acc_out=31, overflow=1.
- Defaults: p=6,6 accepted, then clear=1 together with in_valid=1, p=9 -> 9 not accumulated. Then p=1,1,1,1 -> acc_out=4.
- Defaults: rst_n=0 pulsed after 3 products of a frame -> outputs at reset values. Next 4 products p=2 -> acc_out=8.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the 2x2 multiplier product stream, the
// accumulator and the result consumer.
//
// Valid/ready rule for both channels: a transfer happens on a rising clk
// edge where valid and ready are both 1; the producer holds its data stable
// while valid=1 and ready=0, and ready never depends on valid.
interface product_accumulator_if #(
  parameter int ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  // Producer of products / consumer of results
  modport master (
    output in_valid,
    output p,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  acc_out,
    input  overflow
  );

  // The accumulator itself
  modport slave (
    input  in_valid,
    input  p,
    input  out_ready,
    output in_ready,
    output out_valid,
    output acc_out,
    output overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive 4-bit products from the 2x2
// multiplier and presents the sum as one result behind a valid/ready
// handshake. Two states: ACCUM (taking products) and HOLD (result waiting
// for the consumer).
//
// Optional build macro PRODUCT_ACCUMULATOR_SATURATE_EN: when defined, a
// frame whose running sum carries out of ACC_W bits clamps to all ones for
// the rest of the frame instead of wrapping. Overflow reports 1 either way.
module product_accumulator #(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  product_accumulator_if.slave        bus,
  output logic                        dbg_state_o
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             ovf_q, ovf_d;

  // Datapath for one addition: one extra bit catches the carry out.
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_val;
  logic             last;

  // Add the incoming product to the running sum and pick the stored value
  always_comb begin
    sum   = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, bus.p};
    carry = sum[ACC_W];
    last  = (cnt_q == CNT_LAST);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once a frame has carried, it stays pinned at the maximum value.
    acc_val = (carry || sticky_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_val = sum[ACC_W-1:0];
`endif
  end

  // Next-state and register updates; clear outranks normal operation
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;

    if (clear) begin
      // Abort the frame; acc_out deliberately keeps the last result.
      state_d  = ACCUM;
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (bus.in_valid) begin
            sticky_d = sticky_q | carry;
            if (!last) begin
              acc_d = acc_val;
              cnt_d = cnt_q + 1'b1;
            end else begin
              acc_out_d = acc_val;
              ovf_d     = sticky_q | carry;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            // Result consumed: start a fresh frame from zero.
            state_d  = ACCUM;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
            ovf_d    = 1'b0;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
    end
  end

  // Handshake flags come straight from the state so they can never disagree
  always_comb begin
    bus.in_ready  = (state_q == ACCUM);
    bus.out_valid = (state_q == HOLD);
    bus.acc_out   = acc_out_q;
    bus.overflow  = ovf_q;
    dbg_state_o   = state_q;
  end

  // The frame counter stays within 0..COUNT-1
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_LAST);

  // Overflow is only ever reported alongside a pending result
  a_ovf_with_valid: assert property (@(posedge clk) disable iff (!rst_n)
    ovf_q |-> (state_q == HOLD));

endmodule
